// File: rtl/risc_fetch_stage.sv
// RV32 instruction fetch stage with IF/ID register: owns the PC, issues one outstanding
// imem request at a time, and parks a returned word in a skid buffer when decode stalls.
module risc_fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_valid,
  input  logic                  stall_d,
  input  logic                  pc_redirect,
  input  logic [DATA_WIDTH-1:0] pc_target,
  output logic [DATA_WIDTH-1:0] inst_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc4_d,
  output logic                  valid_d
);

  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DROP = 2'd2} state_t;

  state_t                  state;
  logic                    req_q;
  logic [DATA_WIDTH-1:0]   pc_f;
  logic [DATA_WIDTH-1:0]   skid_inst;
  logic [DATA_WIDTH-1:0]   skid_pc;
  logic [DATA_WIDTH-1:0]   redirect_pc;
  logic                    rsp;

  function automatic logic [DATA_WIDTH-1:0] pc_inc(input logic [DATA_WIDTH-1:0] a);
    return a + DATA_WIDTH'(4);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pc_align(input logic [DATA_WIDTH-1:0] a);
    return a & ~DATA_WIDTH'(3);
  endfunction

  assign rsp       = req_q & imem_valid;
  assign imem_req  = req_q;
  assign imem_addr = pc_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      req_q   <= 1'b0;
      pc_f    <= RESET_PC;
      valid_d <= 1'b0;
      inst_d  <= NOP_INST;
      pc_d    <= '0;
      pc4_d   <= DATA_WIDTH'(4);
    end else if (pc_redirect) begin
      valid_d <= 1'b0;
      inst_d  <= NOP_INST;
      req_q   <= 1'b1;
      // An unanswered request must be drained before the address may change.
      if (state != HOLD && req_q && !imem_valid) begin
        state       <= DROP;
        redirect_pc <= pc_align(pc_target);
      end else begin
        state <= FETCH;
        pc_f  <= pc_align(pc_target);
      end
    end else begin
      case (state)
        FETCH: begin
          req_q <= 1'b1;
          if (rsp) begin
            if (!valid_d || !stall_d) begin
              // IF -> ID boundary
              inst_d  <= imem_rdata;
              pc_d    <= pc_f;
              pc4_d   <= pc_inc(pc_f);
              valid_d <= 1'b1;
              pc_f    <= pc_inc(pc_f);
            end else begin
              skid_inst <= imem_rdata;
              skid_pc   <= pc_f;
              state     <= HOLD;
              req_q     <= 1'b0;
            end
          end else if (!stall_d) begin
            valid_d <= 1'b0;
            inst_d  <= NOP_INST;
          end
        end
        HOLD: begin
          if (!stall_d) begin
            inst_d  <= skid_inst;
            pc_d    <= skid_pc;
            pc4_d   <= pc_inc(skid_pc);
            valid_d <= 1'b1;
            pc_f    <= pc_inc(skid_pc);
            state   <= FETCH;
            req_q   <= 1'b1;
          end
        end
        DROP: begin
          req_q <= 1'b1;
          if (rsp) begin
            pc_f  <= redirect_pc;
            state <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
